// File: rtl/moving_avg_n_pkg.sv
// Shared sizing helpers for the moving-average filter and its ring buffer.
package moving_avg_n_pkg;

  // Largest supported window exponent (window of 64 samples).
  localparam int MAX_LOG2_DEPTH = 6;

  // Width of the full-precision windowed sum.
  function automatic int sum_width(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

  // Constant added before the shift: half an LSB of the average when rounding.
  function automatic int round_const(input int round_mode, input int log2_depth);
    return (round_mode != 0) ? (1 << (log2_depth - 1)) : 0;
  endfunction

endpackage

// File: rtl/mavg_ring_buf.sv
// DEPTH x WIDTH sample history used as a circular delay line.
// The read port always presents the oldest held sample, i.e. the one about to
// be overwritten by the next write.
module mavg_ring_buf
  import moving_avg_n_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic signed [WIDTH-1:0] wr_data,
  output logic signed [WIDTH-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr;

  // Oldest sample sits at the write pointer; it leaves the window on the next write.
  assign oldest = mem[wr_ptr];

  // Pointer advances on each write and wraps naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // History storage: zeroed on reset/clear so a fresh window starts as all-zero samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/moving_avg_n.sv
// N-tap moving-sum / moving-average filter for signed sample streams.
// A running sum is kept incrementally: each accepted sample is added and the
// sample leaving the window is subtracted, so the cost is independent of DEPTH.
module moving_avg_n
  import moving_avg_n_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0,
  parameter int ZERO_FILL  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic signed [WIDTH-1:0]            in,
  output logic                               out_valid,
  output logic signed [WIDTH-1:0]            out,
  output logic signed [WIDTH+LOG2_DEPTH-1:0] sum,
  output logic                               full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);
  localparam int EXT_W = SUM_W + 1;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic signed [EXT_W-1:0] RND_K = EXT_W'(round_const(ROUND, LOG2_DEPTH));
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic                    accept;
  logic signed [WIDTH-1:0] oldest;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [EXT_W-1:0] sum_ext;
  logic signed [WIDTH-1:0] avg_next;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_next;
  logic                    valid_next;

  // A clear in the same cycle as a sample drops the sample.
  assign accept = in_valid & ~clear;

  mavg_ring_buf #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (in),
    .oldest  (oldest)
  );

  // Next running sum, average with optional half-LSB rounding, and occupancy.
  always_comb begin
    sum_next   = sum + {{LOG2_DEPTH{in[WIDTH-1]}}, in}
                     - {{LOG2_DEPTH{oldest[WIDTH-1]}}, oldest};
    sum_ext    = {sum_next[SUM_W-1], sum_next} + RND_K;
    avg_next   = WIDTH'(sum_ext >>> LOG2_DEPTH);
    count_next = (count == DEPTH_CNT) ? count : count + 1'b1;
    valid_next = (ZERO_FILL != 0) ? 1'b1 : (count_next == DEPTH_CNT);
  end

  // Result registers: updated on accepted samples, held otherwise; out_valid pulses once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum       <= '0;
      out       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      out       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sum       <= sum_next;
      out       <= avg_next;
      count     <= count_next;
      out_valid <= valid_next;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign full = (count == DEPTH_CNT);

endmodule

// File: tb/tb_moving_avg_n.sv
// Self-checking bench: three filter configurations share one input stream and are
// compared against a queue-based window model using plain integer arithmetic.
module tb_moving_avg_n;

  localparam int W = 8;
  localparam int L = 2;
  localparam int D = 4;
  localparam int NCFG = 3;

  // Configurations: 0 = zero-fill/truncate, 1 = zero-fill/round, 2 = gated/truncate
  localparam int CFG_ROUND [NCFG] = '{0, 1, 0};
  localparam int CFG_ZF    [NCFG] = '{1, 1, 0};

  logic clk;
  logic rst;
  logic clear;
  logic in_valid;
  logic signed [W-1:0] in_sample;

  logic                  out_valid [NCFG];
  logic signed [W-1:0]   out_avg   [NCFG];
  logic signed [W+L-1:0] sum_out   [NCFG];
  logic                  full_out  [NCFG];

  int err_count;
  int check_count;

  int m_hist [NCFG][$];
  int m_sum   [NCFG];
  int m_out   [NCFG];
  int m_count [NCFG];
  bit m_valid [NCFG];

  moving_avg_n #(.WIDTH(W), .LOG2_DEPTH(L), .ROUND(0), .ZERO_FILL(1)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in_sample),
    .out_valid(out_valid[0]), .out(out_avg[0]), .sum(sum_out[0]), .full(full_out[0]));

  moving_avg_n #(.WIDTH(W), .LOG2_DEPTH(L), .ROUND(1), .ZERO_FILL(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in_sample),
    .out_valid(out_valid[1]), .out(out_avg[1]), .sum(sum_out[1]), .full(full_out[1]));

  moving_avg_n #(.WIDTH(W), .LOG2_DEPTH(L), .ROUND(0), .ZERO_FILL(0)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in(in_sample),
    .out_valid(out_valid[2]), .out(out_avg[2]), .sum(sum_out[2]), .full(full_out[2]));

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Floor division by the window depth, optionally after adding half a step.
  function automatic int model_avg(input int s, input int round_mode);
    int n;
    int q;
    n = s + ((round_mode != 0) ? D / 2 : 0);
    q = n / D;
    if ((n % D != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NCFG; k++) begin
      m_hist[k].delete();
      m_sum[k]   = 0;
      m_out[k]   = 0;
      m_count[k] = 0;
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input int s);
    for (int k = 0; k < NCFG; k++) begin
      int total;
      m_hist[k].push_back(s);
      if (m_hist[k].size() > D) void'(m_hist[k].pop_front());
      total = 0;
      foreach (m_hist[k][i]) total += m_hist[k][i];
      if (m_count[k] < D) m_count[k]++;
      m_sum[k]   = total;
      m_out[k]   = model_avg(total, CFG_ROUND[k]);
      m_valid[k] = (CFG_ZF[k] != 0) || (m_count[k] == D);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NCFG; k++) begin
      checkOutput($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_valid[k]));
      checkOutput($sformatf("sum[%0d]", k), int'(sum_out[k]), m_sum[k]);
      checkOutput($sformatf("out[%0d]", k), int'(out_avg[k]), m_out[k]);
      checkOutput($sformatf("full[%0d]", k), int'(full_out[k]), int'(m_count[k] == D));
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, results are checked just after the rising edge.
  task automatic applyStimulus(input bit v, input int s, input bit c);
    @(negedge clk);
    in_valid  = v;
    in_sample = W'(s);
    clear     = c;
    @(posedge clk);
    if (c) model_clear();
    else if (v) model_accept(s);
    else for (int k = 0; k < NCFG; k++) m_valid[k] = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic do_clear();
    applyStimulus(1'b0, 0, 1'b1);
  endtask

  initial begin
    int t1 [5] = '{8, 4, -4, 12, 16};
    err_count   = 0;
    check_count = 0;
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    model_clear();

    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic window");
    foreach (t1[i]) applyStimulus(1'b1, t1[i], 1'b0);
    checkOutput("t1_sum_final", int'(sum_out[0]), 28);
    checkOutput("t1_out_final", int'(out_avg[0]), 7);
    applyStimulus(1'b0, 0, 1'b0);

    $display("[TB] extremes");
    do_clear();
    repeat (4) applyStimulus(1'b1, 127, 1'b0);
    checkOutput("max_sum", int'(sum_out[0]), 508);
    checkOutput("max_out", int'(out_avg[1]), 127);
    repeat (4) applyStimulus(1'b1, -128, 1'b0);
    checkOutput("min_sum", int'(sum_out[0]), -512);
    checkOutput("min_out", int'(out_avg[0]), -128);

    $display("[TB] rounding");
    do_clear();
    applyStimulus(1'b1, 6, 1'b0);
    repeat (3) applyStimulus(1'b1, 0, 1'b0);
    checkOutput("rnd6_trunc", int'(out_avg[0]), 1);
    checkOutput("rnd6_round", int'(out_avg[1]), 2);
    do_clear();
    applyStimulus(1'b1, -3, 1'b0);
    repeat (3) applyStimulus(1'b1, 0, 1'b0);
    checkOutput("rndm3_trunc", int'(out_avg[0]), -1);
    checkOutput("rndm3_round", int'(out_avg[1]), -1);

    $display("[TB] gated warm-up");
    do_clear();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0);
    checkOutput("gated_sum", int'(sum_out[2]), 14);

    $display("[TB] gaps and clear");
    do_clear();
    applyStimulus(1'b1, 4, 1'b0);
    applyStimulus(1'b0, 55, 1'b0);
    applyStimulus(1'b1, 4, 1'b0);
    applyStimulus(1'b0, 66, 1'b0);
    checkOutput("gap_hold_sum", int'(sum_out[0]), 8);
    applyStimulus(1'b1, 100, 1'b1);
    checkOutput("clr_drop_sum", int'(sum_out[0]), 0);
    applyStimulus(1'b1, 8, 1'b0);
    checkOutput("after_clr_out", int'(out_avg[0]), 2);

    $display("[TB] async reset mid-stream");
    repeat (3) applyStimulus(1'b1, 20, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4, 1'b0);
    checkOutput("post_rst_sum", int'(sum_out[0]), 4);
    checkOutput("post_rst_out", int'(out_avg[0]), 1);

    $display("[TB] random stream");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 4) != 0, int'($urandom_range(255, 0)) - 128,
                    ($urandom % 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
